// File: rtl/fetch_stage_pkg.sv
// Shared constants, the F/D payload type and the fetch-fault helper.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fetch_stage_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam int          IM_DEPTH_DEF = 4096;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

  typedef enum logic [4:0] {
    EXC_NONE = 5'd0,
    EXC_ADEL = 5'd4
  } exc_code_t;

  // F/D pipeline payload.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
    logic        adel;
  } fd_t;

  // Misaligned or outside [base, base + 4*depth). The limit is built in
  // 33 bits so a window ending at 4 GiB cannot wrap to a small value.
  function automatic logic fetch_fault(input logic [31:0] pc,
                                       input logic [31:0] base,
                                       input int unsigned depth);
    logic [32:0] limit;
    limit = {1'b0, base} + (33'(depth) << 2);
    return (pc[1:0] != 2'b00) || (pc < base) || ({1'b0, pc} >= limit);
  endfunction

endpackage

// File: rtl/fetch_stage_fd_pipe_reg.sv
// Generic pipeline register with flush (loads a bubble), stall (holds) and async reset.
// Latency: 1 cycle from d to q.
// Backpressure: stall holds q; flush overrides stall and loads the bubble value.
//
// Ports: clk, reset (async, active-high), stall, flush,
//        d (next payload), bubble (payload loaded on flush), q (registered payload).
module fd_pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  input  logic [W-1:0] d,
  input  logic [W-1:0] bubble,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (flush) begin
      q <= bubble;
    end else if (!stall) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, instruction-memory addressing, AdEL detection, F/D register.
// Latency: next_pc -> PC_F 1 cycle; PC_F -> PC_D/instr_D 1 cycle; im_addr combinational.
// Backpressure: stall holds PC_F and F/D; flush_D inserts a bubble (wins over stall).
//
// Ports: clk, reset (async, active-high); next_pc, stall, flush_D, im_rdata in;
//        im_addr (word index), PC_F, PC_D, instr_D, valid_D, adel_D, fetch_count out.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter int          IM_DEPTH = IM_DEPTH_DEF,
  parameter int          IM_AW    = $clog2(IM_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      next_pc,
  input  logic             stall,
  input  logic             flush_D,
  input  logic [31:0]      im_rdata,
  output logic [IM_AW-1:0] im_addr,
  output logic [31:0]      PC_F,
  output logic [31:0]      PC_D,
  output logic [31:0]      instr_D,
  output logic             valid_D,
  output logic             adel_D,
  output logic [31:0]      fetch_count
);

  logic fault_f;
  fd_t  fd_d;
  fd_t  fd_bubble;
  fd_t  fd_q;

  assign fault_f = fetch_fault(PC_F, IM_BASE, IM_DEPTH);

  // Don't-care when fault_f is set; only the low IM_AW bits matter.
  assign im_addr = PC_F[IM_AW+1:2] - IM_BASE[IM_AW+1:2];

  // next_pc is taken unchecked; a bad target shows up as adel_D once in decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC_F <= RESET_PC;
    end else if (!stall) begin
      PC_F <= next_pc;
    end
  end

  always_comb begin
    fd_d       = '0;
    fd_d.pc    = PC_F;
    fd_d.instr = fault_f ? NOP_INSTR : im_rdata;
    fd_d.valid = 1'b1;
    fd_d.adel  = fault_f;

    // Bubble keeps the PC so exception handling still has an address.
    fd_bubble       = '0;
    fd_bubble.pc    = PC_F;
    fd_bubble.instr = NOP_INSTR;
  end

  fd_pipe_reg #(
    .W       ($bits(fd_t)),
    .RST_VAL ('0)
  ) u_fd (
    .clk    (clk),
    .reset  (reset),
    .stall  (stall),
    .flush  (flush_D),
    .d      (fd_d),
    .bubble (fd_bubble),
    .q      (fd_q)
  );

  assign PC_D    = fd_q.pc;
  assign instr_D = fd_q.instr;
  assign valid_D = fd_q.valid;
  assign adel_D  = fd_q.adel;

  // Counts only real captures of a non-faulting fetch; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
    end else if (!flush_D && !stall && !fault_f) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] next_pc;
  logic        stall;
  logic        flush_D;
  logic [31:0] im_rdata;
  logic [11:0] im_addr;
  logic [31:0] PC_F;
  logic [31:0] PC_D;
  logic [31:0] instr_D;
  logic        valid_D;
  logic        adel_D;
  logic [31:0] fetch_count;

  logic        follow;
  logic [31:0] np_manual;
  int          pass_cnt;
  int          total_cnt;

  assign next_pc = follow ? (PC_F + 32'd4) : np_manual;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .next_pc     (next_pc),
    .stall       (stall),
    .flush_D     (flush_D),
    .im_rdata    (im_rdata),
    .im_addr     (im_addr),
    .PC_F        (PC_F),
    .PC_D        (PC_D),
    .instr_D     (instr_D),
    .valid_D     (valid_D),
    .adel_D      (adel_D),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; flush_D = 1'b0;
    follow = 1'b1; np_manual = 32'h0; im_rdata = 32'h3401_0005;
    tick(); tick();
    reset = 1'b0;
    tick(); tick(); tick();
    // assert reset mid-cycle, away from any edge
    #2;
    reset = 1'b1;
    #1;
    total_cnt++; if (PC_F !== 32'h3000) $display("FAIL rst_pc_f got=%h exp=%h", PC_F, 32'h3000); else pass_cnt++;
    total_cnt++; if (PC_D !== 32'h0) $display("FAIL rst_pc_d got=%h exp=0", PC_D); else pass_cnt++;
    total_cnt++; if (instr_D !== 32'h0) $display("FAIL rst_instr got=%h exp=0", instr_D); else pass_cnt++;
    total_cnt++; if (valid_D !== 1'b0) $display("FAIL rst_valid got=%b exp=0", valid_D); else pass_cnt++;
    total_cnt++; if (adel_D !== 1'b0) $display("FAIL rst_adel got=%b exp=0", adel_D); else pass_cnt++;
    total_cnt++; if (fetch_count !== 32'h0) $display("FAIL rst_count got=%h exp=0", fetch_count); else pass_cnt++;
    total_cnt++; if (im_addr !== 12'h000) $display("FAIL rst_im_addr got=%h exp=000", im_addr); else pass_cnt++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_free_run();
    tick();
    total_cnt++; if (PC_F !== 32'h3004) $display("FAIL run1_pc_f got=%h exp=3004", PC_F); else pass_cnt++;
    total_cnt++; if (PC_D !== 32'h3000) $display("FAIL run1_pc_d got=%h exp=3000", PC_D); else pass_cnt++;
    total_cnt++; if (instr_D !== 32'h3401_0005) $display("FAIL run1_instr got=%h exp=34010005", instr_D); else pass_cnt++;
    total_cnt++; if (valid_D !== 1'b1) $display("FAIL run1_valid got=%b exp=1", valid_D); else pass_cnt++;
    total_cnt++; if (fetch_count !== 32'd1) $display("FAIL run1_count got=%0d exp=1", fetch_count); else pass_cnt++;
    total_cnt++; if (im_addr !== 12'h001) $display("FAIL run1_im_addr got=%h exp=001", im_addr); else pass_cnt++;
    tick();
    total_cnt++; if (PC_F !== 32'h3008) $display("FAIL run2_pc_f got=%h exp=3008", PC_F); else pass_cnt++;
    total_cnt++; if (PC_D !== 32'h3004) $display("FAIL run2_pc_d got=%h exp=3004", PC_D); else pass_cnt++;
    total_cnt++; if (fetch_count !== 32'd2) $display("FAIL run2_count got=%0d exp=2", fetch_count); else pass_cnt++;
  endtask

  task automatic test_stall();
    follow = 1'b0; np_manual = 32'h300C; stall = 1'b1;
    im_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++; if (PC_F !== 32'h3008) $display("FAIL stall_pc_f[%0d] got=%h exp=3008", i, PC_F); else pass_cnt++;
      total_cnt++; if (PC_D !== 32'h3004) $display("FAIL stall_pc_d[%0d] got=%h exp=3004", i, PC_D); else pass_cnt++;
      total_cnt++; if (instr_D !== 32'h3401_0005) $display("FAIL stall_instr[%0d] got=%h exp=34010005", i, instr_D); else pass_cnt++;
      total_cnt++; if (fetch_count !== 32'd2) $display("FAIL stall_count[%0d] got=%0d exp=2", i, fetch_count); else pass_cnt++;
    end
    stall = 1'b0;
    tick();
    total_cnt++; if (PC_F !== 32'h300C) $display("FAIL unstall_pc_f got=%h exp=300c", PC_F); else pass_cnt++;
    total_cnt++; if (PC_D !== 32'h3008) $display("FAIL unstall_pc_d got=%h exp=3008", PC_D); else pass_cnt++;
    total_cnt++; if (instr_D !== 32'hDEAD_BEEF) $display("FAIL unstall_instr got=%h exp=deadbeef", instr_D); else pass_cnt++;
    total_cnt++; if (fetch_count !== 32'd3) $display("FAIL unstall_count got=%0d exp=3", fetch_count); else pass_cnt++;
  endtask

  task automatic test_flush_stall();
    np_manual = 32'h3010; stall = 1'b1; flush_D = 1'b1;
    tick();
    total_cnt++; if (PC_F !== 32'h300C) $display("FAIL flush_pc_f got=%h exp=300c", PC_F); else pass_cnt++;
    total_cnt++; if (PC_D !== 32'h300C) $display("FAIL flush_pc_d got=%h exp=300c", PC_D); else pass_cnt++;
    total_cnt++; if (instr_D !== 32'h0) $display("FAIL flush_instr got=%h exp=0", instr_D); else pass_cnt++;
    total_cnt++; if (valid_D !== 1'b0) $display("FAIL flush_valid got=%b exp=0", valid_D); else pass_cnt++;
    total_cnt++; if (fetch_count !== 32'd3) $display("FAIL flush_count got=%0d exp=3", fetch_count); else pass_cnt++;
    stall = 1'b0; flush_D = 1'b0;
    tick();
    total_cnt++; if (PC_F !== 32'h3010) $display("FAIL refetch_pc_f got=%h exp=3010", PC_F); else pass_cnt++;
    total_cnt++; if (PC_D !== 32'h300C) $display("FAIL refetch_pc_d got=%h exp=300c", PC_D); else pass_cnt++;
    total_cnt++; if (valid_D !== 1'b1) $display("FAIL refetch_valid got=%b exp=1", valid_D); else pass_cnt++;
    total_cnt++; if (fetch_count !== 32'd4) $display("FAIL refetch_count got=%0d exp=4", fetch_count); else pass_cnt++;
  endtask

  task automatic test_misaligned();
    np_manual = 32'h3006;
    tick();
    total_cnt++; if (PC_F !== 32'h3006) $display("FAIL mis_pc_f got=%h exp=3006", PC_F); else pass_cnt++;
    total_cnt++; if (fetch_count !== 32'd5) $display("FAIL mis_count_pre got=%0d exp=5", fetch_count); else pass_cnt++;
    np_manual = 32'h3008;
    tick();
    total_cnt++; if (adel_D !== 1'b1) $display("FAIL mis_adel got=%b exp=1", adel_D); else pass_cnt++;
    total_cnt++; if (instr_D !== 32'h0) $display("FAIL mis_instr got=%h exp=0", instr_D); else pass_cnt++;
    total_cnt++; if (valid_D !== 1'b1) $display("FAIL mis_valid got=%b exp=1", valid_D); else pass_cnt++;
    total_cnt++; if (PC_D !== 32'h3006) $display("FAIL mis_pc_d got=%h exp=3006", PC_D); else pass_cnt++;
    total_cnt++; if (fetch_count !== 32'd5) $display("FAIL mis_count got=%0d exp=5", fetch_count); else pass_cnt++;
  endtask

  task automatic test_range();
    np_manual = 32'h7000;
    tick();
    total_cnt++; if (adel_D !== 1'b0) $display("FAIL rng_adel_3008 got=%b exp=0", adel_D); else pass_cnt++;
    total_cnt++; if (fetch_count !== 32'd6) $display("FAIL rng_count_3008 got=%0d exp=6", fetch_count); else pass_cnt++;
    np_manual = 32'h6FFC;
    tick();
    total_cnt++; if (PC_D !== 32'h7000) $display("FAIL rng_pc_d_7000 got=%h exp=7000", PC_D); else pass_cnt++;
    total_cnt++; if (adel_D !== 1'b1) $display("FAIL rng_adel_7000 got=%b exp=1", adel_D); else pass_cnt++;
    total_cnt++; if (fetch_count !== 32'd6) $display("FAIL rng_count_7000 got=%0d exp=6", fetch_count); else pass_cnt++;
    total_cnt++; if (im_addr !== 12'hFFF) $display("FAIL rng_im_addr_6ffc got=%h exp=fff", im_addr); else pass_cnt++;
    np_manual = 32'h2FFC;
    tick();
    total_cnt++; if (adel_D !== 1'b0) $display("FAIL rng_adel_6ffc got=%b exp=0", adel_D); else pass_cnt++;
    total_cnt++; if (instr_D !== 32'hDEAD_BEEF) $display("FAIL rng_instr_6ffc got=%h exp=deadbeef", instr_D); else pass_cnt++;
    total_cnt++; if (fetch_count !== 32'd7) $display("FAIL rng_count_6ffc got=%0d exp=7", fetch_count); else pass_cnt++;
    np_manual = 32'h3000;
    tick();
    total_cnt++; if (adel_D !== 1'b1) $display("FAIL rng_adel_2ffc got=%b exp=1", adel_D); else pass_cnt++;
    total_cnt++; if (PC_D !== 32'h2FFC) $display("FAIL rng_pc_d_2ffc got=%h exp=2ffc", PC_D); else pass_cnt++;
    total_cnt++; if (fetch_count !== 32'd7) $display("FAIL rng_count_2ffc got=%0d exp=7", fetch_count); else pass_cnt++;
    total_cnt++; if (im_addr !== 12'h000) $display("FAIL rng_im_addr_3000 got=%h exp=000", im_addr); else pass_cnt++;
  endtask

  task automatic test_counter_wrap();
    np_manual = 32'h3004;
    stall = 1'b1;
    force dut.fetch_count = 32'hFFFF_FFFF;
    tick();
    release dut.fetch_count;
    #1;
    total_cnt++; if (fetch_count !== 32'hFFFF_FFFF) $display("FAIL wrap_preload got=%h exp=ffffffff", fetch_count); else pass_cnt++;
    stall = 1'b0;
    tick();
    total_cnt++; if (fetch_count !== 32'h0) $display("FAIL wrap_count got=%h exp=0", fetch_count); else pass_cnt++;
    total_cnt++; if (PC_D !== 32'h3000) $display("FAIL wrap_pc_d got=%h exp=3000", PC_D); else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    test_reset();
    test_free_run();
    test_stall();
    test_flush_stall();
    test_misaligned();
    test_range();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Consumer end of the next-PC interface: registers the selected next PC into PC_F and drives the instruction-memory word address.
- Captures the fetched instruction into the F/D pipeline register, producing PC_D/instr_D for decode, which the next-PC logic reads back.
- Handles stall, flush, instruction-address faults (AdEL) and a retired-fetch counter.

Parameters:
- RESET_PC, 32'h0000_3000, PC_F value after reset.
- IM_BASE, 32'h0000_3000, byte address of instruction-memory word 0.
- IM_DEPTH, 4096, instruction-memory depth in words (power of two).
- IM_AW, 12, word-address width, equal to log2(IM_DEPTH).

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- next_pc  input  32  next fetch address from the next-PC logic.
- stall  input  1  hazard stall: hold PC_F and the F/D register.
- flush_D  input  1  replace the F/D contents with a bubble.
- im_rdata  input  32  instruction word at im_addr; combinational read.
- im_addr  output  IM_AW  word index, (PC_F - IM_BASE) >> 2, low IM_AW bits.
- PC_F  output  32  current fetch PC.
- PC_D  output  32  PC of the instruction in decode.
- instr_D  output  32  instruction in decode.
- valid_D  output  1  instr_D is a real instruction (not a bubble).
- adel_D  output  1  instruction-fetch address fault for the decode instruction.
- fetch_count  output  32  count of valid, non-faulting instructions entering decode.

Behaviour:
- Reset is asynchronous and active-high. While reset is high:
  - PC_F = RESET_PC.
  - PC_D = 0, instr_D = 0, valid_D = 0, adel_D = 0, fetch_count = 0.
- Fault detection (combinational on PC_F):
  - fault_F = (PC_F[1:0] != 0) or (PC_F < IM_BASE) or (PC_F >= IM_BASE + 4*IM_DEPTH).
  - Compute the upper bound in 33 bits so the limit cannot wrap.
- im_addr = PC_F[IM_AW+1:2] - IM_BASE[IM_AW+1:2], truncated to IM_AW bits. It is don't-care when fault_F is set.
- PC register, per rising edge:
  - stall = 1: PC_F holds.
  - Otherwise: PC_F <= next_pc.
  - next_pc is not checked. A bad next_pc faults one cycle later, when it reaches decode.
- F/D register, per rising edge, in priority order:
  1. flush_D = 1 (wins over stall):
     - instr_D <= 0, valid_D <= 0, adel_D <= 0.
     - PC_D <= PC_F, so exception handling still has a PC.
  2. stall = 1: all F/D outputs hold.
  3. Otherwise:
     - PC_D <= PC_F.
     - instr_D <= fault_F ? 0 : im_rdata.
     - valid_D <= 1.
     - adel_D <= fault_F.
- stall and flush_D together: PC_F holds and a bubble enters decode. The instruction held in F is refetched next cycle.
- fetch_count increments by 1 only on a case-3 capture with fault_F = 0. It wraps from 32'hFFFF_FFFF to 0.
- Latency:
  - next_pc to PC_F: 1 cycle.
  - PC_F to PC_D/instr_D: 1 cycle.
  - Branch/jump targets computed from PC_D appear on PC_F one cycle after resolution. The delay-slot instruction is the one already in F and is not flushed by this block.
- Reset asserted mid-operation: all state returns to reset values immediately, regardless of clk, stall or flush_D.
- All outputs come directly from registers, except im_addr, which is combinational from PC_F.

Decomposition:
- Shared package constants: RESET_PC, IM_BASE, IM_DEPTH, NOP_INSTR = 32'h0000_0000, and the AdEL exception code (4).
- One sub-module, fd_pipe_reg: the F/D register with stall, flush and asynchronous-reset logic. It is reused later for the D/E, E/M and M/W registers with different widths.

Test Plan:
- Reset and free run: assert reset mid-cycle, release it, drive next_pc = PC_F+4 with im_rdata = 32'h3401_0005.
  - PC_F = 0x3000 immediately on reset.
  - Next edges: PC_F = 0x3004, then PC_D = 0x3000, instr_D = 0x34010005, valid_D = 1, fetch_count = 1.
- Stall: with PC_F = 0x3008, hold stall = 1 for 2 cycles, with next_pc = 0x300C.
  - PC_F stays 0x3008; PC_D and instr_D are unchanged; fetch_count is unchanged.
  - On release, PC_F = 0x300C.
- Flush during stall: stall = 1 and flush_D = 1 for one edge.
  - PC_F holds; instr_D = 0, valid_D = 0, PC_D = held PC_F; fetch_count is unchanged.
- Misaligned fetch: next_pc = 0x3006.
  - One edge later, PC_F = 0x3006.
  - Next edge: adel_D = 1, instr_D = 0, valid_D = 1, PC_D = 0x3006; fetch_count is not incremented.
- Out-of-range fetch:
  - next_pc = 0x7000 (IM_BASE + 4*4096): adel_D = 1 when the instruction reaches decode.
  - next_pc = 0x6FFC: no fault, im_addr = 12'hFFF.
  - next_pc = 0x2FFC: adel_D = 1.
- Counter wrap: preload fetch_count = 32'hFFFF_FFFF via a bench force, then one valid fetch → fetch_count = 0.
